// File: rtl/pll_vga_reset_seq_if.sv
// Purpose: groups the PLL sequencer's control and status signals into one bundle.
// Latency: none; this file only declares wires.
// Backpressure: none; all signals are level-based.
// Signals: soft_rst and pll_locked flow into the sequencer.
//          pll_rst, sys_rst, ready, retry_cnt and lost_cnt flow out of it.
interface pll_vga_reset_seq_if;
    logic       soft_rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retry_cnt;
    logic [3:0] lost_cnt;

    // Sequencer side.
    modport master (
        input  soft_rst,
        input  pll_locked,
        output pll_rst,
        output sys_rst,
        output ready,
        output retry_cnt,
        output lost_cnt
    );

    // Side that drives requests and observes status (PLL wrapper or bench).
    modport slave (
        output soft_rst,
        output pll_locked,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  retry_cnt,
        input  lost_cnt
    );
endinterface

// File: rtl/pll_vga_reset_seq.sv
// Purpose: resets the 108 MHz VGA PLL and holds the video pipeline in reset until lock is stable.
// Latency: a pll_locked change reaches lk_s in 2 refclk edges; outputs react 1 edge after that.
// Backpressure: none; soft_rst is a single-cycle request and is accepted in any state.
// Ports: refclk (50 MHz reference, the only clock), rst (async, active high), bus (master modport).
//        bus carries soft_rst, pll_locked, pll_rst, sys_rst, ready, retry_cnt and lost_cnt.
module pll_vga_reset_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 50000
) (
    input  logic                refclk,
    input  logic                rst,
    pll_vga_reset_seq_if.master bus
);

    localparam int MAX_A = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
    localparam int MAX_C = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES);
    localparam logic [CW-1:0] STB_LD = CW'(LOCK_STABLE);
    localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          lk_meta_q;
    logic          lk_s_q;
    logic          pll_rst_q;
    logic          sys_rst_q;
    logic          ready_q;
    logic [3:0]    retry_q;
    logic [3:0]    lost_q;

    // One register block for the synchronizer, the FSM and every output.
    // The shared counter is reloaded on each state entry. A value of 1 marks
    // the last cycle of the current window, so a load of N expires on the
    // Nth edge after entry.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= RST_LD;
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            retry_q   <= 4'd0;
            lost_q    <= 4'd0;
        end else begin
            lk_meta_q <= bus.pll_locked;
            lk_s_q    <= lk_meta_q;

            if (bus.soft_rst) begin
                // A soft reset overrides any transition due this cycle,
                // including a coincident lock loss or timeout. Neither is counted.
                state_q   <= RESET_PLL;
                cnt_q     <= RST_LD;
                pll_rst_q <= 1'b1;
                sys_rst_q <= 1'b1;
                ready_q   <= 1'b0;
            end else begin
                case (state_q)
                    RESET_PLL: begin
                        if (cnt_q == ONE) begin
                            state_q   <= WAIT_LOCK;
                            cnt_q     <= TO_LD;
                            pll_rst_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lk_s_q) begin
                            state_q <= STABLE;
                            cnt_q   <= STB_LD;
                        end else if (cnt_q == ONE) begin
                            state_q   <= RESET_PLL;
                            cnt_q     <= RST_LD;
                            pll_rst_q <= 1'b1;
                            if (retry_q != 4'hF) begin
                                retry_q <= retry_q + 4'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    STABLE: begin
                        // Any drop sends the FSM back through WAIT_LOCK. The full
                        // stability window then starts again from zero.
                        if (!lk_s_q) begin
                            state_q <= WAIT_LOCK;
                            cnt_q   <= TO_LD;
                        end else if (cnt_q == ONE) begin
                            state_q   <= RUN;
                            sys_rst_q <= 1'b0;
                            ready_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - ONE;
                        end
                    end
                    RUN: begin
                        if (!lk_s_q) begin
                            state_q   <= RESET_PLL;
                            cnt_q     <= RST_LD;
                            pll_rst_q <= 1'b1;
                            sys_rst_q <= 1'b1;
                            ready_q   <= 1'b0;
                            if (lost_q != 4'hF) begin
                                lost_q <= lost_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= RESET_PLL;
                        cnt_q     <= RST_LD;
                        pll_rst_q <= 1'b1;
                        sys_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.retry_cnt = retry_q;
    assign bus.lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_vga_reset_seq.sv
// Purpose: directed self-checking bench for pll_vga_reset_seq (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=20).
// Latency: outputs are sampled 1 ns after each rising refclk edge.
// Backpressure: none.
module tb_pll_vga_reset_seq;

    logic refclk;
    logic rst;
    int   total;
    int   bad;

    pll_vga_reset_seq_if bus ();

    pll_vga_reset_seq #(
        .RST_CYCLES  (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(20)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the complete reset output state, including ready == !sys_rst.
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, {31'd0, bus.pll_rst}, 32'd1);
        chk({tag, "_sys_rst"}, {31'd0, bus.sys_rst}, 32'd1);
        chk({tag, "_ready"},   {31'd0, bus.ready},   32'd0);
        chk({tag, "_retry"},   {28'd0, bus.retry_cnt}, 32'd0);
        chk({tag, "_lost"},    {28'd0, bus.lost_cnt},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst             = 1'b1;
        bus.soft_rst    = 1'b0;
        bus.pll_locked  = 1'b0;
        repeat (2) step();
        chk_reset_vals("rst_hold");

        // 1: clean bring-up. rst is released between edges; the next edge is edge 1.
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("s1_pll_rst_hi", {31'd0, bus.pll_rst}, 32'd1);
        end
        step();                                   // edge 4
        chk("s1_pll_rst_fall", {31'd0, bus.pll_rst}, 32'd0);
        bus.pll_locked = 1'b1;
        for (int i = 5; i <= 14; i++) begin
            step();
            chk("s1_ready_lo", {31'd0, bus.ready}, 32'd0);
        end
        step();                                   // edge 15
        chk("s1_ready_hi",   {31'd0, bus.ready},     32'd1);
        chk("s1_sys_rst_lo", {31'd0, bus.sys_rst},   32'd0);
        chk("s1_retry",      {28'd0, bus.retry_cnt}, 32'd0);
        chk("s1_lost",       {28'd0, bus.lost_cnt},  32'd0);

        // 4: lock loss in RUN. Outputs react 3 edges after the fall.
        bus.pll_locked = 1'b0;
        step();
        step();
        chk("s4_ready_still", {31'd0, bus.ready}, 32'd1);
        step();
        chk("s4_ready_lo",  {31'd0, bus.ready},    32'd0);
        chk("s4_sys_rst",   {31'd0, bus.sys_rst},  32'd1);
        chk("s4_pll_rst",   {31'd0, bus.pll_rst},  32'd1);
        chk("s4_lost",      {28'd0, bus.lost_cnt}, 32'd1);
        bus.pll_locked = 1'b1;
        repeat (3) step();
        chk("s4_pll_rst_hold", {31'd0, bus.pll_rst}, 32'd1);
        step();                                   // WAIT_LOCK; lk_s is already 1
        chk("s4_pll_rst_fall", {31'd0, bus.pll_rst}, 32'd0);
        repeat (8) step();                        // STABLE entered at +5, release at +13
        chk("s4_ready_pre", {31'd0, bus.ready}, 32'd0);
        step();
        chk("s4_recover", {31'd0, bus.ready}, 32'd1);

        // 5: soft_rst sampled in the same cycle that lk_s is low in RUN.
        bus.pll_locked = 1'b0;
        step();
        step();                                   // lk_s is now 0
        bus.soft_rst = 1'b1;
        step();
        bus.soft_rst = 1'b0;
        chk("s5_pll_rst", {31'd0, bus.pll_rst},  32'd1);
        chk("s5_ready",   {31'd0, bus.ready},    32'd0);
        chk("s5_lost",    {28'd0, bus.lost_cnt}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("s5_pll_rst_hi", {31'd0, bus.pll_rst}, 32'd1);
        end
        step();
        chk("s5_pll_rst_fall", {31'd0, bus.pll_rst}, 32'd0);

        // 2: lock timeout. pll_locked stays low; WAIT_LOCK began on the last edge.
        repeat (19) step();
        chk("s2_pre_to_pll", {31'd0, bus.pll_rst},   32'd0);
        chk("s2_pre_to_cnt", {28'd0, bus.retry_cnt}, 32'd0);
        step();
        chk("s2_to1_pll",  {31'd0, bus.pll_rst},   32'd1);
        chk("s2_to1_cnt",  {28'd0, bus.retry_cnt}, 32'd1);
        repeat (24) step();
        chk("s2_to2_pll",  {31'd0, bus.pll_rst},   32'd1);
        chk("s2_to2_cnt",  {28'd0, bus.retry_cnt}, 32'd2);
        for (int i = 0; i < 18; i++) begin
            repeat (24) step();
        end
        chk("s2_sat",      {28'd0, bus.retry_cnt}, 32'd15);
        chk("s2_lost",     {28'd0, bus.lost_cnt},  32'd1);
        chk("s2_sys_rst",  {31'd0, bus.sys_rst},   32'd1);

        // 3: glitch in STABLE. RESET_PLL was entered on the last edge.
        bus.pll_locked = 1'b1;
        repeat (4) step();
        chk("s3_pll_rst_fall", {31'd0, bus.pll_rst}, 32'd0);
        step();                                   // S: STABLE entry
        step();
        step();                                   // S+2
        bus.pll_locked = 1'b0;
        repeat (3) step();                        // S+5
        bus.pll_locked = 1'b1;
        for (int i = 6; i <= 15; i++) begin
            step();
            chk("s3_ready_lo", {31'd0, bus.ready}, 32'd0);
        end
        step();                                   // S+16
        chk("s3_ready_hi", {31'd0, bus.ready},     32'd1);
        chk("s3_retry",    {28'd0, bus.retry_cnt}, 32'd15);

        // 6: async reset in STABLE with nonzero counts.
        bus.soft_rst = 1'b1;
        step();
        bus.soft_rst = 1'b0;
        chk("s6_soft_pll", {31'd0, bus.pll_rst},   32'd1);
        chk("s6_soft_lost",{28'd0, bus.lost_cnt},  32'd1);
        repeat (4) step();
        chk("s6_pll_rst_fall", {31'd0, bus.pll_rst}, 32'd0);
        step();                                   // STABLE entry
        step();
        chk("s6_stable_sys", {31'd0, bus.sys_rst}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("s6_async");
        #5;
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
